// File: rtl/ccl_pkg.sv
// Shared types and helpers for the connected-components frame controller.
package ccl_pkg;

  localparam int LABEL_W = 16;

  typedef enum logic [2:0] {
    CLEAR,
    WAIT_SOF,
    LABEL,
    RES_A,
    RES_B,
    RES_W,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_READ_I,
    FL_READ_EQ,
    FL_WRITE
  } flat_state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ccl_label_flattener.sv
// Walks labels 1..num_labels-1 in ascending order, rewriting each equivalence
// entry with its root: read eq[i], read eq[eq[i]], write eq[i].
module ccl_label_flattener
  import ccl_pkg::*;
#(
  parameter int MAX_LABELS = 1024,
  parameter int LABEL_W    = ccl_pkg::LABEL_W
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start,
  input  logic [LABEL_W-1:0]              num_labels,
  input  logic [LABEL_W-1:0]              rdata,
  output logic [addr_w(MAX_LABELS)-1:0]   addr,
  output logic                            we,
  output logic [LABEL_W-1:0]              wdata,
  output logic                            done,
  output flat_state_t                     state
);

  localparam int AW = addr_w(MAX_LABELS);

  logic [LABEL_W-1:0] idx;
  logic [LABEL_W-1:0] last;
  logic [LABEL_W-1:0] eq_i;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= FL_IDLE;
      idx   <= '0;
      last  <= '0;
      eq_i  <= '0;
    end else begin
      case (state)
        FL_IDLE: begin
          if (start && (num_labels > LABEL_W'(1))) begin
            idx   <= LABEL_W'(1);
            last  <= num_labels - LABEL_W'(1);
            state <= FL_READ_I;
          end
        end
        FL_READ_I:  state <= FL_READ_EQ;
        FL_READ_EQ: begin
          eq_i  <= rdata;
          state <= FL_WRITE;
        end
        FL_WRITE: begin
          if (idx == last) begin
            state <= FL_IDLE;
          end else begin
            idx   <= idx + LABEL_W'(1);
            state <= FL_READ_I;
          end
        end
        default: state <= FL_IDLE;
      endcase
    end
  end

  // The second read address comes straight from the table's read data, so
  // the table port is decoded combinationally from the phase.
  always_comb begin
    addr  = '0;
    we    = 1'b0;
    wdata = '0;
    case (state)
      FL_READ_I:  addr = idx[AW-1:0];
      FL_READ_EQ: addr = rdata[AW-1:0];
      FL_WRITE: begin
        addr  = idx[AW-1:0];
        we    = 1'b1;
        // An entry pointing at itself or forward is already a root.
        wdata = (eq_i >= idx) ? idx : rdata;
      end
      default: ;
    endcase
  end

  assign done = (state == FL_WRITE) && (idx == last);

endmodule

// File: rtl/ccl_frame_sequencer.sv
// Frame-level controller: clears tables, gates one frame into the labeler,
// flattens equivalences during blanking and holds results until acknowledged.
module ccl_frame_sequencer
  import ccl_pkg::*;
#(
  parameter int HRES       = 320,
  parameter int VRES       = 180,
  parameter int MAX_LABELS = 1024,
  parameter int LABEL_W    = ccl_pkg::LABEL_W
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [10:0]                     hcount_in,
  input  logic [9:0]                      vcount_in,
  input  logic                            valid_in,
  input  logic [LABEL_W-1:0]              next_label_in,
  output logic                            pix_en_out,
  output logic                            lbl_rst_out,
  output logic                            area_clr_out,
  output logic [addr_w(MAX_LABELS)-1:0]   tbl_addr_out,
  output logic                            tbl_we_out,
  output logic [LABEL_W-1:0]              tbl_wdata_out,
  input  logic [LABEL_W-1:0]              tbl_rdata_in,
  output logic                            done_out,
  input  logic                            ack_in,
  output logic [LABEL_W-1:0]              num_labels_out,
  output logic                            overflow_out,
  output logic [7:0]                      dropped_out
);

  localparam int AW = addr_w(MAX_LABELS);
  localparam logic [LABEL_W-1:0] MAX_LBL = LABEL_W'(MAX_LABELS);

  state_t             state;
  logic               clr_run;
  logic [AW-1:0]      clr_cnt;
  logic               sof;
  logic               eof;
  logic               clr_last;
  logic [LABEL_W-1:0] num_clamped;
  logic               flat_start;
  logic [AW-1:0]      flat_addr;
  logic               flat_we;
  logic [LABEL_W-1:0] flat_wdata;
  logic               flat_done;
  flat_state_t        flat_state;

  assign sof = valid_in && (hcount_in == '0) && (vcount_in == '0);
  assign eof = valid_in && (hcount_in == 11'(HRES - 1)) && (vcount_in == 10'(VRES - 1));
  assign clr_last    = (clr_cnt == AW'(MAX_LABELS - 1));
  assign num_clamped = (next_label_in > MAX_LBL) ? MAX_LBL : next_label_in;
  assign flat_start  = (state == LABEL) && !sof && eof;

  // done_out/ack_in handshake: done_out is a level that stays high until the
  // consumer raises ack_in for a cycle; the tables are released on that edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= CLEAR;
      clr_run        <= 1'b0;
      clr_cnt        <= '0;
      num_labels_out <= '0;
      overflow_out   <= 1'b0;
      dropped_out    <= '0;
    end else begin
      if (sof && (state != WAIT_SOF) && (dropped_out != 8'hFF))
        dropped_out <= dropped_out + 8'd1;
      case (state)
        CLEAR: begin
          if (!clr_run) begin
            clr_run <= 1'b1;
          end else if (clr_last) begin
            clr_run <= 1'b0;
            clr_cnt <= '0;
            state   <= WAIT_SOF;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        WAIT_SOF: begin
          if (sof) begin
            overflow_out <= 1'b0;
            state        <= LABEL;
          end
        end
        LABEL: begin
          if (next_label_in >= MAX_LBL) overflow_out <= 1'b1;
          if (sof) begin
            clr_run <= 1'b1;
            clr_cnt <= '0;
            state   <= CLEAR;
          end else if (eof) begin
            num_labels_out <= num_clamped;
            state          <= (num_clamped <= LABEL_W'(1)) ? DONE : RES_A;
          end
        end
        RES_A: state <= RES_B;
        RES_B: state <= RES_W;
        RES_W: state <= flat_done ? DONE : RES_A;
        DONE: begin
          if (ack_in) begin
            clr_run <= 1'b1;
            clr_cnt <= '0;
            state   <= CLEAR;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  ccl_label_flattener #(
    .MAX_LABELS (MAX_LABELS),
    .LABEL_W    (LABEL_W)
  ) u_flat (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start      (flat_start),
    .num_labels (num_clamped),
    .rdata      (tbl_rdata_in),
    .addr       (flat_addr),
    .we         (flat_we),
    .wdata      (flat_wdata),
    .done       (flat_done),
    .state      (flat_state)
  );

  assign pix_en_out   = valid_in && ((state == LABEL) || ((state == WAIT_SOF) && sof));
  assign done_out     = (state == DONE);
  assign area_clr_out = clr_run;
  assign lbl_rst_out  = clr_run && clr_last;

  always_comb begin
    tbl_addr_out  = '0;
    tbl_we_out    = 1'b0;
    tbl_wdata_out = '0;
    if (flat_state != FL_IDLE) begin
      tbl_addr_out  = flat_addr;
      tbl_we_out    = flat_we;
      tbl_wdata_out = flat_wdata;
    end else if (clr_run) begin
      tbl_addr_out  = clr_cnt;
      tbl_we_out    = 1'b1;
      tbl_wdata_out = LABEL_W'(clr_cnt);
    end
  end

endmodule
